baseaddr_slot_track: RTL and testbench

//  Ownership tracker for the 5 frame-buffer base-address slots in the baseaddr loop.
//  It sits directly upstream of bit5_encode:
//  - free_mask feeds bit5_encode.code.
//  - The writer claims the slot index that bit5_encode returns.

---
 rtl/baseaddr_slot_track.sv | 122 ++++++++++++
 tb/tb_baseaddr_slot_track.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/baseaddr_slot_track.sv
// Ownership tracker for the five frame-buffer base-address slots.
// Newest completed frame wins; an unread READY frame is dropped when replaced.
module baseaddr_slot_track #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_claim,
  input  logic [2:0]       wr_claim_idx,
  input  logic             wr_done,
  input  logic             rd_claim,
  input  logic             rd_release,
  output logic [4:0]       free_mask,
  output logic             wr_busy,
  output logic [2:0]       wr_idx,
  output logic             rdy_valid,
  output logic             rd_busy,
  output logic [2:0]       rd_idx,
  output logic             repeat_pls,
  output logic             err_pls,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] repeat_cnt
);

  logic [2:0]       rdy_idx;
  logic             wr_busy_n;
  logic [2:0]       wr_idx_n;
  logic             rdy_valid_n;
  logic [2:0]       rdy_idx_n;
  logic             rd_busy_n;
  logic [2:0]       rd_idx_n;
  logic [4:0]       free_n;
  logic             rep;
  logic             err;
  logic             drop;
  logic             wd;
  logic             claim_ok;
  logic [7:0]       fm8;

  function automatic logic [4:0] oh(input logic [2:0] i);
    return 5'(5'd1 << i);
  endfunction

  always_comb begin
    wr_busy_n   = wr_busy;
    wr_idx_n    = wr_idx;
    rdy_valid_n = rdy_valid;
    rdy_idx_n   = rdy_idx;
    rd_busy_n   = rd_busy;
    rd_idx_n    = rd_idx;
    rep         = 1'b0;
    drop        = 1'b0;
    fm8         = {3'b000, free_mask};
    wd          = wr_done & wr_busy;
    claim_ok    = wr_claim && (wr_claim_idx <= 3'd4)
                  && fm8[wr_claim_idx]
                  && (!wr_busy || wr_done);
    err = (wr_claim & ~claim_ok)
        | (wr_done & ~wr_busy)
        | (rd_release & ~rd_claim & ~rd_busy);

    // reader sees only the READY frame present before this edge
    if (rd_claim) begin
      if (rdy_valid) begin
        rd_busy_n   = 1'b1;
        rd_idx_n    = rdy_idx;
        rdy_valid_n = 1'b0;
      end else begin
        rep = 1'b1;
      end
    end else if (rd_release && rd_busy) begin
      rd_busy_n = 1'b0;
    end

    if (wd) begin
      drop        = rdy_valid & ~rd_claim;
      rdy_valid_n = 1'b1;
      rdy_idx_n   = wr_idx;
      wr_busy_n   = 1'b0;
    end

    if (claim_ok) begin
      wr_busy_n = 1'b1;
      wr_idx_n  = wr_claim_idx;
    end

    free_n = ~(({5{wr_busy_n}} & oh(wr_idx_n))
             | ({5{rdy_valid_n}} & oh(rdy_idx_n))
             | ({5{rd_busy_n}} & oh(rd_idx_n)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_mask  <= 5'b11111;
      wr_busy    <= 1'b0;
      wr_idx     <= 3'd0;
      rdy_valid  <= 1'b0;
      rdy_idx    <= 3'd0;
      rd_busy    <= 1'b0;
      rd_idx     <= 3'd0;
      repeat_pls <= 1'b0;
      err_pls    <= 1'b0;
      drop_cnt   <= '0;
      repeat_cnt <= '0;
    end else begin
      free_mask  <= free_n;
      wr_busy    <= wr_busy_n;
      wr_idx     <= wr_idx_n;
      rdy_valid  <= rdy_valid_n;
      rdy_idx    <= rdy_idx_n;
      rd_busy    <= rd_busy_n;
      rd_idx     <= rd_idx_n;
      repeat_pls <= rep;
      err_pls    <= err;
      if (drop && !(&drop_cnt))
        drop_cnt <= drop_cnt + 1'b1;
      if (rep && !(&repeat_cnt))
        repeat_cnt <= repeat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_baseaddr_slot_track.sv
// Bench for baseaddr_slot_track: slot-array model, per-cycle compare,
// directed pinning scenarios and a randomized encoder-loop run.
module tb_baseaddr_slot_track;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_claim = 1'b0;
  logic [2:0]       wr_claim_idx = 3'd0;
  logic             wr_done = 1'b0;
  logic             rd_claim = 1'b0;
  logic             rd_release = 1'b0;
  logic [4:0]       free_mask;
  logic             wr_busy;
  logic [2:0]       wr_idx;
  logic             rdy_valid;
  logic             rd_busy;
  logic [2:0]       rd_idx;
  logic             repeat_pls;
  logic             err_pls;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] repeat_cnt;

  baseaddr_slot_track #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_claim(wr_claim), .wr_claim_idx(wr_claim_idx),
    .wr_done(wr_done), .rd_claim(rd_claim),
    .rd_release(rd_release), .free_mask(free_mask),
    .wr_busy(wr_busy), .wr_idx(wr_idx),
    .rdy_valid(rdy_valid), .rd_busy(rd_busy),
    .rd_idx(rd_idx), .repeat_pls(repeat_pls),
    .err_pls(err_pls), .drop_cnt(drop_cnt),
    .repeat_cnt(repeat_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int {FREE, WRITING, READY, READING} st_e;
  st_e ms [5];
  int  m_drop, m_rep, m_wr_idx, m_rd_idx;
  bit  m_err, m_repp;
  int  n_chk = 0;
  int  n_pass = 0;
  bit  chk_en = 1'b0;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d @%0t", nm, got, exp, $time);
  endtask

  function automatic int find(input st_e s);
    for (int i = 0; i < 5; i++) if (ms[i] == s) return i;
    return -1;
  endfunction

  function automatic int m_free();
    int f = 0;
    for (int i = 0; i < 5; i++) if (ms[i] == FREE) f |= (1 << i);
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) ms[i] = FREE;
    m_drop = 0; m_rep = 0; m_wr_idx = 0; m_rd_idx = 0;
    m_err = 0; m_repp = 0;
  endtask

  task automatic model_step();
    int w, r, d, ci;
    bit wd, ok;
    w = find(WRITING); r = find(READY); d = find(READING);
    ci = int'(wr_claim_idx);
    wd = wr_done && (w >= 0);
    m_err = 0; m_repp = 0;
    ok = 0;
    if (wr_claim && ci <= 4)
      ok = (ms[ci] == FREE) && (w < 0 || wr_done);
    if (wr_claim && !ok) m_err = 1;
    if (wr_done && w < 0) m_err = 1;
    if (rd_claim) begin
      if (r >= 0) begin
        if (d >= 0) ms[d] = FREE;
        ms[r] = READING;
        m_rd_idx = r;
      end else begin
        m_repp = 1;
        if (m_rep < 65535) m_rep++;
      end
    end else if (rd_release) begin
      if (d >= 0) ms[d] = FREE;
      else m_err = 1;
    end
    if (wd) begin
      if (r >= 0 && ms[r] == READY) begin
        ms[r] = FREE;
        if (m_drop < 65535) m_drop++;
      end
      ms[w] = READY;
    end
    if (ok) begin
      ms[ci] = WRITING;
      m_wr_idx = ci;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int pc;
      chk("free_mask", int'(free_mask), m_free());
      chk("wr_busy", int'(wr_busy), int'(find(WRITING) >= 0));
      chk("rdy_valid", int'(rdy_valid), int'(find(READY) >= 0));
      chk("rd_busy", int'(rd_busy), int'(find(READING) >= 0));
      if (wr_busy) chk("wr_idx", int'(wr_idx), m_wr_idx);
      if (rd_busy) chk("rd_idx", int'(rd_idx), m_rd_idx);
      chk("repeat_pls", int'(repeat_pls), int'(m_repp));
      chk("err_pls", int'(err_pls), int'(m_err));
      chk("drop_cnt", int'(drop_cnt), m_drop);
      chk("repeat_cnt", int'(repeat_cnt), m_rep);
      pc = $countones(free_mask);
      chk("inv_count", pc,
          5 - int'(wr_busy) - int'(rdy_valid) - int'(rd_busy));
      if (wr_busy && rd_busy)
        chk("inv_distinct", int'(wr_idx != rd_idx), 1);
    end
  end

  task automatic step(input bit c, input int idx, input bit d,
                      input bit rc, input bit rr);
    @(negedge clk);
    #1;
    wr_claim = c; wr_claim_idx = 3'(idx);
    wr_done = d; rd_claim = rc; rd_release = rr;
    @(posedge clk);
    model_step();
    #1;
    wr_claim = 0; wr_done = 0; rd_claim = 0; rd_release = 0;
  endtask

  task automatic do_reset();
    chk_en = 0;
    @(negedge clk);
    #3 rst_n = 0;
    model_reset();
    #1;
    chk("rst_free", int'(free_mask), 31);
    chk("rst_busy", int'({wr_busy, rdy_valid, rd_busy}), 0);
    chk("rst_pls", int'({repeat_pls, err_pls}), 0);
    chk("rst_idx", int'({wr_idx, rd_idx}), 0);
    chk("rst_cnt", int'(drop_cnt) + int'(repeat_cnt), 0);
    @(negedge clk);
    #1 rst_n = 1;
    chk_en = 1;
  endtask

  function automatic int enc5(input logic [4:0] m);
    for (int i = 0; i < 5; i++) if (m[i]) return i;
    return 5;
  endfunction

  initial begin
    int frames, cyc;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // 1: claim 0 then complete
    step(1, 0, 0, 0, 0);
    chk("t1_free", int'(free_mask), 5'b11110);
    chk("t1_wr", int'({wr_busy, wr_idx}), 4'b1000);
    step(0, 0, 1, 0, 0);
    chk("t1_rdy", int'(rdy_valid), 1);
    chk("t1_free2", int'(free_mask), 5'b11110);

    // 2: two newer frames with no reader
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 2, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("t2_drop", int'(drop_cnt), 2);
    chk("t2_free", int'(free_mask), 5'b11011);

    // 3: READY=1 READING=0 WRITING=2, claim+done together
    do_reset();
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 2, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    chk("t3_rd", int'({rd_busy, rd_idx}), 4'b1001);
    chk("t3_rdy", int'(rdy_valid), 1);
    chk("t3_free", int'(free_mask), 5'b11001);
    chk("t3_drop", int'(drop_cnt), 0);

    // 4: repeat with reader on slot 3
    do_reset();
    step(1, 3, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("t4_rep", int'(repeat_pls), 1);
    chk("t4_cnt", int'(repeat_cnt), 1);
    chk("t4_rd", int'(rd_idx), 3);

    // 5: illegal requests
    step(1, 3, 0, 0, 0);
    chk("t5_busy", int'(err_pls), 1);
    chk("t5_free", int'(free_mask), 5'b10111);
    step(1, 5, 0, 0, 0);
    chk("t5_idx", int'(err_pls), 1);
    step(0, 0, 1, 0, 0);
    chk("t5_done", int'(err_pls), 1);
    chk("t5_free2", int'(free_mask), 5'b10111);
    step(0, 0, 0, 0, 0);
    chk("t5_clr", int'(err_pls), 0);

    // 6: all three roles occupied, then async reset
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 2, 0, 0, 0);
    chk("t6_occ", int'({wr_busy, rdy_valid, rd_busy}), 3'b111);
    do_reset();

    // random loop with free_mask fed through a lowest-index encoder
    frames = 0; cyc = 0;
    while (frames < 100 && cyc < 20000) begin
      bit c, d, rc, rr;
      int idx;
      c = 0; d = 0; idx = enc5(free_mask);
      if (!wr_busy && $urandom_range(2) == 0) c = 1;
      if ($urandom_range(15) == 0) begin
        c = 1; idx = $urandom_range(7);
      end
      if (wr_busy && $urandom_range(3) == 0) d = 1;
      if (!wr_busy && $urandom_range(31) == 0) d = 1;
      rc = ($urandom_range(4) == 0);
      rr = ($urandom_range(6) == 0);
      if (d && wr_busy) frames++;
      step(c, idx, d, rc, rr);
      cyc++;
    end
    chk("rand_frames", int'(frames >= 100), 1);
    step(0, 0, 0, 0, 0);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
